// File: rtl/imem_boot_pkg.sv
// Shared definitions for the polirv instruction memory boot loader:
// FSM state encoding, the fill value for unloaded words and image framing sizes.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        LOAD,
        CHK,
        RUN,
        ERR
    } boot_state_t;

    localparam logic [31:0] NOP_WORD       = 32'h00000013;
    localparam int          HDR_BYTES      = 2;
    localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_byte_assembler.sv
// Packs a stream of strobed bytes into little-endian 32-bit words; word_strobe
// marks the fourth byte, when word carries the complete value combinationally.
module byte_assembler
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        strobe,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_strobe
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0] idx;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx <= 2'd0;
        end else if (strobe) begin
            idx <= idx + 2'd1;
        end
    end

    // Byte holding registers carry data only, so they need no reset.
    always_ff @(posedge clk) begin
        if (strobe) begin
            case (idx)
                2'd0:    b0 <= in_byte;
                2'd1:    b1 <= in_byte;
                2'd2:    b2 <= in_byte;
                default: ;
            endcase
        end
    end

    assign word        = {in_byte, b2, b1, b0};
    assign word_strobe = strobe && (idx == LAST_IDX);

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory with serial byte-stream boot loader for the polirv core.
// Optional trailing XOR checksum byte is enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int          i_addr_bits = 6,
    parameter logic [31:0] NOP_WORD    = imem_boot_pkg::NOP_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [7:0]             ld_byte,
    input  logic [i_addr_bits-1:0] i_mem_addr,
    output logic [31:0]            i_mem_data,
    output logic                   core_rst_n,
    output logic                   boot_done,
    output logic                   boot_err,
    output logic [i_addr_bits-2:0] words_loaded
);

    localparam int                     DEPTH   = 2 ** (i_addr_bits - 2);
    localparam int                     AW      = i_addr_bits - 2;
    localparam logic [15:0]            DEPTH16 = 16'(DEPTH);
    localparam logic [i_addr_bits-2:0] WL_ONE  = 1;

    boot_state_t state;
    boot_state_t state_next;

    logic        xfer;
    logic [7:0]  n_lo;
    logic [15:0] n_words;
    logic [15:0] n_full;
    logic        last_word;
    logic [31:0] asm_word;
    logic        asm_strobe;
    logic [31:0] mem [DEPTH];
    logic        unused_addr_lsbs;

    assign ld_ready  = (state == HDR0) || (state == HDR1) ||
                       (state == LOAD) || (state == CHK);
    assign xfer      = ld_valid && ld_ready;
    assign n_full    = {ld_byte, n_lo};
    assign last_word = (16'(words_loaded) == (n_words - 16'd1));

    byte_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (ld_byte),
        .strobe      (xfer && (state == LOAD)),
        .clear       (state != LOAD),
        .word        (asm_word),
        .word_strobe (asm_strobe)
    );

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= 8'd0;
        end else if (xfer && (state == LOAD)) begin
            csum <= csum ^ ld_byte;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HDR0: if (xfer) state_next = HDR1;
            HDR1: begin
                // Validate the full 16-bit count, so N=256 cannot alias to 0.
                if (xfer) begin
                    if ((n_full == 16'd0) || (n_full > DEPTH16)) state_next = ERR;
                    else                                         state_next = LOAD;
                end
            end
            LOAD: begin
                if (asm_strobe && last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = RUN;
`endif
                end
            end
            CHK: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                if (xfer) state_next = (ld_byte == csum) ? RUN : ERR;
`else
                state_next = ERR;
`endif
            end
            default: ;
        endcase
    end

    assign core_rst_n = (state == RUN);
    assign boot_done  = (state == RUN);
    assign boot_err   = (state == ERR);

    always_ff @(posedge clk) begin
        if (xfer && (state == HDR0)) n_lo <= ld_byte;
        if (xfer && (state == HDR1)) n_words <= n_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            words_loaded <= '0;
        end else if ((state == LOAD) && asm_strobe) begin
            words_loaded <= words_loaded + WL_ONE;
        end
    end

    // The array is reset so a re-boot never exposes a stale partial image.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
        end else if ((state == LOAD) && asm_strobe) begin
            mem[words_loaded[AW-1:0]] <= asm_word;
        end
    end

    assign i_mem_data       = mem[i_mem_addr[i_addr_bits-1:2]];
    assign unused_addr_lsbs = ^i_mem_addr[1:0];

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus queues expectations, a monitor
// checks them against DUT outputs. Honours IMEM_BOOT_CHECKSUM_EN like the RTL.
module tb_imem_boot_loader;
    import imem_boot_pkg::*;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int K_READ = 0;
    localparam int K_STAT = 1;
    localparam int K_TERM = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_byte;
    logic [5:0]  i_mem_addr;
    logic [31:0] i_mem_data;
    logic        core_rst_n;
    logic        boot_done;
    logic        boot_err;
    logic [4:0]  words_loaded;

    always #5 clk = ~clk;

    imem_boot_loader #(.i_addr_bits(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_byte      (ld_byte),
        .i_mem_addr   (i_mem_addr),
        .i_mem_data   (i_mem_data),
        .core_rst_n   (core_rst_n),
        .boot_done    (boot_done),
        .boot_err     (boot_err),
        .words_loaded (words_loaded)
    );

    typedef struct {
        int          kind;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  flags;   // {ld_ready, core_rst_n, boot_done, boot_err}
        int          wl;
        int          xfers;
        string       name;
    } exp_t;

    exp_t       q[$];
    logic [7:0] img[$];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per falling edge; terminal entries wait
    // for boot_done/boot_err to rise and check the handshake count/latency.
    logic term_prev = 1'b0;
    logic hs_prev   = 1'b0;
    logic term;
    int   mon_xfers = 0;
    exp_t me;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_xfers = 0;
                term_prev = 1'b0;
                hs_prev   = 1'b0;
            end else begin
                term = boot_done | boot_err;
                if (term && !term_prev) begin
                    if (q.size() > 0 && q[0].kind == K_TERM) begin
                        me = q.pop_front();
                        chk({me.name, "_flags"}, 32'({ld_ready, core_rst_n, boot_done, boot_err}), 32'(me.flags));
                        chk({me.name, "_words"}, 32'(words_loaded), 32'(me.wl));
                        chk({me.name, "_xfers"}, 32'(mon_xfers), 32'(me.xfers));
                        chk({me.name, "_latency"}, 32'(hs_prev), 32'd1);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_terminal: got done=%0b err=%0b expected no transition", boot_done, boot_err);
                    end
                end else if (q.size() > 0 && q[0].kind != K_TERM) begin
                    me = q.pop_front();
                    if (me.kind == K_READ) begin
                        i_mem_addr = me.addr;
                        #1;
                        chk(me.name, i_mem_data, me.data);
                    end else begin
                        chk({me.name, "_flags"}, 32'({ld_ready, core_rst_n, boot_done, boot_err}), 32'(me.flags));
                        chk({me.name, "_words"}, 32'(words_loaded), 32'(me.wl));
                    end
                end
                term_prev = term;
                hs_prev   = ld_valid && ld_ready;
                if (hs_prev) mon_xfers++;
            end
        end
    end

    task automatic exp_read(input string n, input logic [5:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = K_READ; e.addr = a; e.data = d; e.flags = 4'd0; e.wl = 0; e.xfers = 0; e.name = n;
        q.push_back(e);
    endtask

    task automatic exp_stat(input string n, input logic [3:0] f, input int wl);
        exp_t e;
        e.kind = K_STAT; e.addr = 6'd0; e.data = 32'd0; e.flags = f; e.wl = wl; e.xfers = 0; e.name = n;
        q.push_back(e);
    endtask

    task automatic exp_term(input string n, input logic [3:0] f, input int wl, input int xf);
        exp_t e;
        e.kind = K_TERM; e.addr = 6'd0; e.data = 32'd0; e.flags = f; e.wl = wl; e.xfers = xf; e.name = n;
        q.push_back(e);
    endtask

    task automatic drain(input string n);
        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0 pending", n, q.size());
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ld_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        if (gap > 0) begin
            ld_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        for (int i = 0; i < 50; i++) begin
            rdy = ld_ready;
            @(posedge clk);
            #1;
            if (rdy) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got ld_ready=0 for byte %h expected a transfer", b);
        ld_valid = 1'b0;
    endtask

    task automatic send_image(input int maxgap);
        foreach (img[i]) send_byte(img[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        ld_valid = 1'b0;
    endtask

    task automatic nominal_reads(input string n);
        exp_read({n, "_w0"}, 6'd0, 32'h00100093);
        exp_read({n, "_w1"}, 6'd4, 32'h00200113);
        exp_read({n, "_w2"}, 6'd8, NOP);
        exp_read({n, "_w0_lsb"}, 6'd3, 32'h00100093);
        exp_read({n, "_w15"}, 6'd60, NOP);
    endtask

    task automatic nominal_image();
        img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        if (CS != 0) img.push_back(8'hB1);
    endtask

    task automatic hdr_err(input string n, input logic [7:0] lo, input logic [7:0] hi);
        do_reset();
        img = '{lo, hi};
        exp_term(n, 4'b0001, 0, HDR_BYTES);
        send_image(0);
        drain(n);
        exp_read({n, "_w0"}, 6'd0, NOP);
        drain(n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; i_mem_addr = 6'd0;

        do_reset();
        exp_stat("reset", 4'b1000, 0);
        exp_read("reset_w0", 6'd0, NOP);
        exp_read("reset_w15", 6'd60, NOP);
        drain("reset");

        nominal_image();
        exp_term("nominal", 4'b0110, 2, HDR_BYTES + 8 + CS);
        send_image(0);
        drain("nominal");
        nominal_reads("nominal");
        drain("nominal");

        ld_valid = 1'b1;
        ld_byte  = 8'hFF;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        ld_valid = 1'b0;
        exp_stat("after_run", 4'b0110, 2);
        nominal_reads("after_run");
        drain("after_run");

        do_reset();
        nominal_image();
        exp_term("gaps", 4'b0110, 2, HDR_BYTES + 8 + CS);
        send_image(3);
        drain("gaps");
        nominal_reads("gaps");
        drain("gaps");

        hdr_err("hdr_n0", 8'h00, 8'h00);
        hdr_err("hdr_n17", 8'h11, 8'h00);
        hdr_err("hdr_n256", 8'h00, 8'h01);

        do_reset();
        img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10};
        send_image(0);
        do_reset();
        img = '{8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        if (CS != 0) img.push_back(8'h00);
        exp_term("midload", 4'b0110, 1, HDR_BYTES + 4 + CS);
        send_image(0);
        drain("midload");
        exp_read("midload_w0", 6'd0, 32'hAABBCCDD);
        exp_read("midload_w1", 6'd4, NOP);
        exp_read("midload_w15", 6'd60, NOP);
        drain("midload");

`ifdef IMEM_BOOT_CHECKSUM_EN
        do_reset();
        img = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        exp_term("csum_ok", 4'b0110, 1, 7);
        send_image(0);
        drain("csum_ok");
        exp_read("csum_ok_w0", 6'd0, 32'h04030201);
        drain("csum_ok");

        do_reset();
        img = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        exp_term("csum_bad", 4'b0001, 1, 7);
        send_image(0);
        drain("csum_bad");
        exp_read("csum_bad_w0", 6'd0, 32'h04030201);
        exp_stat("csum_bad_hold", 4'b0001, 1);
        drain("csum_bad");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
